// File: rtl/avalon_memory_arbiter.sv
// avalon_memory_arbiter: round-robin sharing of one fixed-latency memory port,
// with an owner-tag pipeline that steers each returning read to its issuer.
module avalon_memory_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSWIDTH     = 32,
  parameter int ADDRESSWIDTH = 10,
  parameter int LATENCY      = 1,
  parameter int IDWIDTH      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_read,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_address,
  input  logic [NUM_REQ*BUSWIDTH-1:0]     req_data_in,
  output logic [NUM_REQ-1:0]              req_waitrequest,
  output logic [NUM_REQ-1:0]              req_read_valid,
  output logic [BUSWIDTH-1:0]             req_data_out,
  output logic                            m_read,
  output logic                            m_write,
  output logic [ADDRESSWIDTH-1:0]         m_address,
  output logic [BUSWIDTH-1:0]             m_data_in,
  input  logic                            m_read_valid,
  input  logic [BUSWIDTH-1:0]             m_data_out,
  output logic                            route_error
);

  logic [NUM_REQ-1:0]              active;
  logic [IDWIDTH-1:0]              last_grant;
  logic                            grant_valid;
  logic [IDWIDTH-1:0]              grant_id;
  logic [LATENCY-1:0]              tag_valid;
  logic [LATENCY-1:0][IDWIDTH-1:0] tag_id;
  logic                            tail_valid;
  logic [IDWIDTH-1:0]              tail_id;
  logic                            hit;

  assign active = req_read | req_write;

  // First active requester after last_grant, wrapping around.
  always_comb begin
    logic [IDWIDTH-1:0] cand;
    cand        = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDWIDTH'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_valid && !reset && active[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    req_waitrequest = '1;
    m_read          = 1'b0;
    m_write         = 1'b0;
    m_address       = '0;
    m_data_in       = '0;
    if (grant_valid) begin
      req_waitrequest[grant_id] = 1'b0;
      m_write   = req_write[grant_id];
      m_read    = req_read[grant_id] & ~req_write[grant_id];
      m_address = req_address[int'(grant_id)*ADDRESSWIDTH +: ADDRESSWIDTH];
      m_data_in = req_data_in[int'(grant_id)*BUSWIDTH +: BUSWIDTH];
    end
  end

  assign tail_valid = tag_valid[LATENCY-1];
  assign tail_id    = tag_id[LATENCY-1];
  assign hit        = !reset && m_read_valid && tail_valid;

  always_comb begin
    req_read_valid = '0;
    req_data_out   = '0;
    if (hit) begin
      req_read_valid[tail_id] = 1'b1;
      req_data_out            = m_data_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= IDWIDTH'(NUM_REQ - 1);
      tag_valid   <= '0;
      tag_id      <= '0;
      route_error <= 1'b0;
    end else begin
      if (grant_valid)
        last_grant <= grant_id;
      tag_valid[0] <= m_read;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
      // A return without a tag, or a tag without a return, is a lost owner.
      if (m_read_valid != tail_valid)
        route_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_memory_arbiter.sv
// tb_avalon_memory_arbiter: directed tests of arbitration, routing and reset
// against a small behavioural memory with LATENCY=2 and late write commit.
module tb_avalon_memory_arbiter;

  localparam int N   = 4;
  localparam int BW  = 32;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_read;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_address;
  logic [N*BW-1:0] req_data_in;
  logic [N-1:0]    req_waitrequest;
  logic [N-1:0]    req_read_valid;
  logic [BW-1:0]   req_data_out;
  logic            m_read;
  logic            m_write;
  logic [AW-1:0]   m_address;
  logic [BW-1:0]   m_data_in;
  logic            m_read_valid;
  logic [BW-1:0]   m_data_out;
  logic            route_error;
  logic            force_rv;

  int n_cmp = 0;
  int n_bad = 0;

  avalon_memory_arbiter #(
    .NUM_REQ(N), .BUSWIDTH(BW), .ADDRESSWIDTH(AW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_data_in(req_data_in),
    .req_waitrequest(req_waitrequest), .req_read_valid(req_read_valid),
    .req_data_out(req_data_out),
    .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_data_in(m_data_in),
    .m_read_valid(m_read_valid), .m_data_out(m_data_out),
    .route_error(route_error)
  );

  always #5 clk = ~clk;

  // Memory model: reads sample at issue, writes land one cycle late.
  logic [BW-1:0]  mem [0:(1<<AW)-1];
  logic [LAT-1:0] rv_pipe;
  logic [BW-1:0]  rd_pipe [LAT];
  logic           w_pend;
  logic [AW-1:0]  w_addr;
  logic [BW-1:0]  w_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_pipe <= '0;
      w_pend  <= 1'b0;
      for (int i = 0; i < (1<<AW); i++)
        mem[i] <= 32'hD000_0000 + i;
    end else begin
      rv_pipe    <= {rv_pipe[LAT-2:0], m_read};
      rd_pipe[0] <= mem[m_address];
      rd_pipe[1] <= rd_pipe[0];
      w_pend     <= m_write;
      w_addr     <= m_address;
      w_data     <= m_data_in;
      if (w_pend)
        mem[w_addr] <= w_data;
    end
  end

  assign m_read_valid = rv_pipe[LAT-1] | force_rv;
  assign m_data_out   = rd_pipe[LAT-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_read[i]             = rd;
    req_write[i]            = wr;
    req_address[i*AW +: AW] = a;
    req_data_in[i*BW +: BW] = d;
  endtask

  task automatic test_reset;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'b0, AW'(16*(i+1)), '0);
    tick;
    #3;
    n_cmp++; if (req_waitrequest !== 4'hF) begin n_bad++; $display("FAIL rst_wait got %h want f", req_waitrequest); end
    n_cmp++; if (m_read !== 1'b0 || m_write !== 1'b0) begin n_bad++; $display("FAIL rst_cmd got r%b w%b want 0 0", m_read, m_write); end
    n_cmp++; if (req_read_valid !== 4'h0) begin n_bad++; $display("FAIL rst_rv got %h want 0", req_read_valid); end
    n_cmp++; if (req_data_out !== 32'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", req_data_out); end
    n_cmp++; if (route_error !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", route_error); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [N-1:0]  ew;
    logic [N-1:0]  erv;
    logic [AW-1:0] ea;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'b0, AW'(16*(i+1)), '0);
    reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      #3;
      ew  = (c < 4) ? ~(4'b1 << c) : 4'hF;
      erv = (c >= 2 && c < 6) ? (4'b1 << (c-2)) : 4'h0;
      n_cmp++; if (req_waitrequest !== ew) begin n_bad++; $display("FAIL rr_wait c=%0d got %h want %h", c, req_waitrequest, ew); end
      if (c < 4) begin
        ea = AW'(16*(c+1));
        n_cmp++; if (m_read !== 1'b1 || m_address !== ea) begin n_bad++; $display("FAIL rr_cmd c=%0d got r%b a%h want r1 a%h", c, m_read, m_address, ea); end
      end
      n_cmp++; if (req_read_valid !== erv) begin n_bad++; $display("FAIL rr_rv c=%0d got %h want %h", c, req_read_valid, erv); end
      if (erv != 0) begin
        n_cmp++; if (req_data_out !== 32'hD000_0000 + 16*(c-1)) begin n_bad++; $display("FAIL rr_data c=%0d got %h want %h", c, req_data_out, 32'hD000_0000 + 16*(c-1)); end
      end
      tick;
      if (c < 4) req_read[c] = 1'b0;
    end
  endtask

  task automatic test_alternate;
    int g;
    int pg;
    logic [AW-1:0] ea;
    set_req(1, 1'b1, 1'b0, 10'h100, '0);
    set_req(3, 1'b1, 1'b0, 10'h300, '0);
    for (int c = 0; c < 8; c++) begin
      if (c == 6) begin req_read[1] = 1'b0; req_read[3] = 1'b0; end
      #3;
      g = (c % 2 == 1) ? 3 : 1;
      if (c < 6) begin
        ea = (g == 1) ? 10'h100 : 10'h300;
        n_cmp++; if (req_waitrequest !== ~(4'b1 << g) || m_address !== ea) begin n_bad++; $display("FAIL alt_grant c=%0d got w%h a%h want w%h a%h", c, req_waitrequest, m_address, ~(4'b1 << g), ea); end
      end
      if (c >= 2) begin
        pg = g;
        ea = (pg == 1) ? 10'h100 : 10'h300;
        n_cmp++; if (req_read_valid !== (4'b1 << pg) || req_data_out !== 32'hD000_0000 + ea) begin n_bad++; $display("FAIL alt_ret c=%0d got rv%h d%h want rv%h d%h", c, req_read_valid, req_data_out, 4'b1 << pg, 32'hD000_0000 + ea); end
      end
      tick;
    end
  endtask

  task automatic test_rw_both;
    set_req(2, 1'b1, 1'b1, 10'h005, 32'hA5A5_A5A5);
    #3;
    n_cmp++; if (req_waitrequest !== 4'b1011) begin n_bad++; $display("FAIL rw_wait got %h want b", req_waitrequest); end
    n_cmp++; if (m_write !== 1'b1 || m_read !== 1'b0) begin n_bad++; $display("FAIL rw_cmd got r%b w%b want r0 w1", m_read, m_write); end
    n_cmp++; if (m_address !== 10'h005 || m_data_in !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL rw_bus got a%h d%h want a005 da5a5a5a5", m_address, m_data_in); end
    tick;
    set_req(2, 1'b0, 1'b0, '0, '0);
    for (int c = 1; c < 4; c++) begin
      #3;
      n_cmp++; if (req_read_valid !== 4'h0) begin n_bad++; $display("FAIL rw_norv c=%0d got %h want 0", c, req_read_valid); end
      tick;
    end
    set_req(2, 1'b1, 1'b0, 10'h005, '0);
    #3;
    n_cmp++; if (req_waitrequest !== 4'b1011 || m_read !== 1'b1) begin n_bad++; $display("FAIL rw_rd got w%h r%b want wb r1", req_waitrequest, m_read); end
    tick;
    set_req(2, 1'b0, 1'b0, '0, '0);
    #3;
    n_cmp++; if (req_read_valid !== 4'h0) begin n_bad++; $display("FAIL rw_early got %h want 0", req_read_valid); end
    tick;
    #3;
    n_cmp++; if (req_read_valid !== 4'b0100 || req_data_out !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL rw_ret got rv%h d%h want rv4 da5a5a5a5", req_read_valid, req_data_out); end
    tick;
  endtask

  task automatic test_write_then_read;
    set_req(0, 1'b0, 1'b1, 10'h007, 32'h11);
    #3;
    n_cmp++; if (req_waitrequest !== 4'b1110 || m_write !== 1'b1) begin n_bad++; $display("FAIL wr_cmd got w%h mw%b want we mw1", req_waitrequest, m_write); end
    tick;
    set_req(0, 1'b1, 1'b0, 10'h007, '0);
    #3;
    n_cmp++; if (m_read !== 1'b1 || m_write !== 1'b0) begin n_bad++; $display("FAIL wr_rd got r%b w%b want r1 w0", m_read, m_write); end
    tick;
    set_req(0, 1'b0, 1'b0, '0, '0);
    #3;
    n_cmp++; if (req_read_valid !== 4'h0) begin n_bad++; $display("FAIL wr_early got %h want 0", req_read_valid); end
    tick;
    #3;
    n_cmp++; if (req_read_valid !== 4'b0001 || req_data_out !== 32'hD000_0007) begin n_bad++; $display("FAIL wr_old got rv%h d%h want rv1 dd0000007", req_read_valid, req_data_out); end
    tick;
    #3;
    n_cmp++; if (req_read_valid !== 4'h0) begin n_bad++; $display("FAIL wr_late got %h want 0", req_read_valid); end
    tick;
  endtask

  task automatic test_reset_inflight;
    set_req(0, 1'b1, 1'b0, 10'h020, '0);
    set_req(1, 1'b1, 1'b0, 10'h021, '0);
    #3;
    n_cmp++; if (req_waitrequest !== 4'b1101) begin n_bad++; $display("FAIL ri_g1 got %h want d", req_waitrequest); end
    tick;
    set_req(1, 1'b0, 1'b0, '0, '0);
    #3;
    n_cmp++; if (req_waitrequest !== 4'b1110 || m_read !== 1'b1) begin n_bad++; $display("FAIL ri_g0 got w%h r%b want we r1", req_waitrequest, m_read); end
    tick;
    set_req(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #3;
    n_cmp++; if (req_read_valid !== 4'h0 || req_waitrequest !== 4'hF) begin n_bad++; $display("FAIL ri_inrst got rv%h w%h want rv0 wf", req_read_valid, req_waitrequest); end
    tick;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #3;
      n_cmp++; if (req_read_valid !== 4'h0 || route_error !== 1'b0) begin n_bad++; $display("FAIL ri_drop c=%0d got rv%h e%b want rv0 e0", c, req_read_valid, route_error); end
      tick;
    end
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, 1'b0, AW'(48 + i), '0);
    #3;
    n_cmp++; if (req_waitrequest !== 4'b1110) begin n_bad++; $display("FAIL ri_first got %h want e", req_waitrequest); end
    tick;
    req_read = '0;
    #3;
    n_cmp++; if (req_read_valid !== 4'h0) begin n_bad++; $display("FAIL ri_early got %h want 0", req_read_valid); end
    tick;
    #3;
    n_cmp++; if (req_read_valid !== 4'b0001 || req_data_out !== 32'hD000_0030) begin n_bad++; $display("FAIL ri_ret got rv%h d%h want rv1 dd0000030", req_read_valid, req_data_out); end
    tick;
  endtask

  task automatic test_route_error;
    force_rv = 1'b1;
    #3;
    n_cmp++; if (req_read_valid !== 4'h0 || route_error !== 1'b0) begin n_bad++; $display("FAIL re_now got rv%h e%b want rv0 e0", req_read_valid, route_error); end
    tick;
    force_rv = 1'b0;
    for (int c = 1; c < 4; c++) begin
      #3;
      n_cmp++; if (route_error !== 1'b1 || req_read_valid !== 4'h0) begin n_bad++; $display("FAIL re_sticky c=%0d got e%b rv%h want e1 rv0", c, route_error, req_read_valid); end
      tick;
    end
  endtask

  initial begin
    req_read    = '0;
    req_write   = '0;
    req_address = '0;
    req_data_in = '0;
    force_rv    = 1'b0;
    tick;
    test_reset;
    test_round_robin;
    test_alternate;
    test_rw_both;
    test_write_then_read;
    test_reset_inflight;
    test_route_error;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
